// File: rtl/apsk_demap_pkg.sv
// Shared constants for the APSK demapper slice: CORDIC arctangent table, mode encodings,
// ring geometry and (with PHASE_ERR_EN) the sector-centre table.
package apsk_demap_pkg;

   localparam int ATAN_W = 12;
   localparam int ATAN_N = 7;

   // round(atan(2^-i) * 4096/360), one entry per micro-rotation stage
   localparam logic [ATAN_W-1:0] ATAN_LUT [ATAN_N] = '{
      12'd512, 12'd302, 12'd160, 12'd81, 12'd41, 12'd20, 12'd10
   };

   typedef enum logic [1:0] {
      MODE_16APSK   = 2'd0,
      MODE_32APSK   = 2'd1,
      MODE_QPSK     = 2'd2,
      MODE_QPSK_ALT = 2'd3
   } mode_e;

   localparam int RING_NSECT [3] = '{4, 12, 16};
   localparam int RING2_OFFSET   = 128;

`ifdef PHASE_ERR_EN
   // floor(((2*s+1) * 4096) / 24) for the 12-sector ring, padded to 16 entries
   localparam logic [11:0] CENTRE_R1 [16] = '{
      12'd170,  12'd512,  12'd853,  12'd1194, 12'd1536, 12'd1877, 12'd2218, 12'd2560,
      12'd2901, 12'd3242, 12'd3584, 12'd3925, 12'd0,    12'd0,    12'd0,    12'd0
   };

   function automatic logic [11:0] sector_centre(input logic [1:0] ring, input logic [3:0] sector);
      case (ring)
         2'd0:    return {sector[1:0], 1'b1, 9'd0};
         2'd1:    return CENTRE_R1[sector];
         2'd2:    return {sector, 1'b1, 7'd0};
         default: return 12'd0;
      endcase
   endfunction
`endif

endpackage

// File: rtl/cordic_phase_ring_slicer_if.sv
// Sample/result bundle between the vectoring CORDIC and the ring/sector slicer.
// phase_err is present only when PHASE_ERR_EN is defined.
interface cordic_phase_ring_slicer_if #(
   parameter int WL   = 18,
   parameter int PW   = 12,
   parameter int NSTG = 7
);
   logic                 in_valid;
   logic                 pre_rot;
   logic                 dir_pre;
   logic [NSTG-1:0]      dir;
   logic signed [WL-1:0] mag;
   logic [1:0]           mode;
   logic [WL-1:0]        r1_th;
   logic [WL-1:0]        r2_th;

   logic                 out_valid;
   logic [1:0]           ring;
   logic [4:0]           sector;
   logic [PW-1:0]        phase;
   logic signed [WL-1:0] mag_o;
`ifdef PHASE_ERR_EN
   logic signed [7:0]    phase_err;
`endif

   modport master (
      output in_valid, pre_rot, dir_pre, dir, mag, mode, r1_th, r2_th,
`ifdef PHASE_ERR_EN
      input  phase_err,
`endif
      input  out_valid, ring, sector, phase, mag_o
   );

   modport slave (
      input  in_valid, pre_rot, dir_pre, dir, mag, mode, r1_th, r2_th,
`ifdef PHASE_ERR_EN
      output phase_err,
`endif
      output out_valid, ring, sector, phase, mag_o
   );

endinterface

// File: rtl/cordic_phase_accum.sv
// Absolute phase from CORDIC pre-rotation flags and micro-rotation directions.
// Purely combinational; the caller registers the result.
module cordic_phase_accum
   import apsk_demap_pkg::*;
#(
   parameter int PW   = 12,
   parameter int NSTG = 7
) (
   input  logic            pre_rot,
   input  logic            dir_pre,
   input  logic [NSTG-1:0] dir,
   output logic [PW-1:0]   phase
);

   logic [PW-1:0] acc;

   // Pre-rotation lands on a quarter (y>=0) or three-quarter (y<0) turn; sums wrap mod 2^PW
   always_comb begin
      acc = '0;
      if (pre_rot)
         acc = dir_pre ? PW'(3) << (PW - 2) : PW'(1) << (PW - 2);
      for (int i = 0; i < NSTG; i++)
         acc = dir[i] ? acc - PW'(ATAN_LUT[i]) : acc + PW'(ATAN_LUT[i]);
      phase = acc;
   end

endmodule

// File: rtl/cordic_phase_ring_slicer.sv
// Two-stage slicer: stage 1 registers phase/magnitude/ring, stage 2 registers the sector.
// Optional PHASE_ERR_EN adds a saturated phase-to-sector-centre error output.
module cordic_phase_ring_slicer
   import apsk_demap_pkg::*;
#(
   parameter int WL   = 18,
   parameter int PW   = 12,
   parameter int NSTG = 7
) (
   input logic                       clk,
   input logic                       rst_n,
   cordic_phase_ring_slicer_if.slave bus
);

   logic [PW-1:0]        phase_d;
   logic [WL-1:0]        mag_eff;
   logic [1:0]           ring_d;

   logic                 s1_valid;
   logic [PW-1:0]        s1_phase;
   logic signed [WL-1:0] s1_mag;
   logic [1:0]           s1_ring;

   logic [PW-1:0]        rot_phase;
   logic [PW+3:0]        x12;
   logic [4:0]           sector_d;

   logic                 out_valid_q;
   logic [1:0]           ring_q;
   logic [4:0]           sector_q;
   logic [PW-1:0]        phase_q;
   logic signed [WL-1:0] mag_q;

   cordic_phase_accum #(.PW(PW), .NSTG(NSTG)) u_accum (
      .pre_rot (bus.pre_rot),
      .dir_pre (bus.dir_pre),
      .dir     (bus.dir),
      .phase   (phase_d)
   );

   // Negative magnitudes compare as zero; thresholds are checked in fixed priority order
   always_comb begin
      mag_eff = bus.mag[WL-1] ? '0 : bus.mag;
      ring_d  = 2'd0;
      if (bus.mode == MODE_QPSK || bus.mode == MODE_QPSK_ALT)
         ring_d = 2'd0;
      else if (mag_eff < bus.r1_th)
         ring_d = 2'd0;
      else if (mag_eff < bus.r2_th || bus.mode == MODE_16APSK)
         ring_d = 2'd1;
      else
         ring_d = 2'd2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_phase <= '0;
         s1_mag   <= '0;
         s1_ring  <= '0;
      end else begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_phase <= phase_d;
            s1_mag   <= bus.mag;
            s1_ring  <= ring_d;
         end
      end
   end

   // Sector = (rot * N) >> PW with N in {4,12,16}; x12 built from two shifts
   always_comb begin
      rot_phase = (s1_ring == 2'd2) ? s1_phase + PW'(RING2_OFFSET) : s1_phase;
      x12       = ({4'b0, rot_phase} << 3) + ({4'b0, rot_phase} << 2);
      case (s1_ring)
         2'd0:    sector_d = {3'b0, rot_phase[PW-1 -: 2]};
         2'd1:    sector_d = {1'b0, x12[PW+3 -: 4]};
         2'd2:    sector_d = {1'b0, rot_phase[PW-1 -: 4]};
         default: sector_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         ring_q      <= '0;
         sector_q    <= '0;
         phase_q     <= '0;
         mag_q       <= '0;
      end else begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            ring_q   <= s1_ring;
            sector_q <= sector_d;
            phase_q  <= s1_phase;
            mag_q    <= s1_mag;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.ring      = ring_q;
   assign bus.sector    = sector_q;
   assign bus.phase     = phase_q;
   assign bus.mag_o     = mag_q;

`ifdef PHASE_ERR_EN
   logic signed [PW:0] err_wide;
   logic signed [7:0]  err_d;
   logic signed [7:0]  err_q;

   always_comb begin
      err_wide = $signed({1'b0, rot_phase}) - $signed({1'b0, sector_centre(s1_ring, sector_d[3:0])});
      if (err_wide > 127)
         err_d = 8'sd127;
      else if (err_wide < -128)
         err_d = -8'sd128;
      else
         err_d = err_wide[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= '0;
      else if (s1_valid)
         err_q <= err_d;
   end

   assign bus.phase_err = err_q;
`endif

endmodule

// File: tb/tb_cordic_phase_ring_slicer.sv
// Bench for cordic_phase_ring_slicer: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_cordic_phase_ring_slicer;

   logic clk = 1'b0;
   logic rst_n;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cordic_phase_ring_slicer_if #(.WL(18), .PW(12), .NSTG(7)) bus ();

   cordic_phase_ring_slicer #(.WL(18), .PW(12), .NSTG(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit v;
      int phase;
      int ring;
      int sector;
      int mag;
      int err;
   } exp_t;

   function automatic exp_t model(bit v, bit pr, bit dp, logic [6:0] d, logic [17:0] m18,
                                  int mode, int r1, int r2);
      exp_t e;
      int   a[7];
      int   ph, m, meff, n, rot, c;
      a  = '{512, 302, 160, 81, 41, 20, 10};
      ph = pr ? (dp ? 3072 : 1024) : 0;
      for (int i = 0; i < 7; i++) ph += d[i] ? -a[i] : a[i];
      ph   = ((ph % 4096) + 4096) % 4096;
      m    = int'($signed(m18));
      meff = (m < 0) ? 0 : m;
      if (mode >= 2)                      e.ring = 0;
      else if (meff < r1)                 e.ring = 0;
      else if (meff < r2 || mode == 0)    e.ring = 1;
      else                                e.ring = 2;
      n        = (e.ring == 0) ? 4 : (e.ring == 1) ? 12 : 16;
      rot      = (e.ring == 2) ? (ph + 128) % 4096 : ph;
      e.v      = v;
      e.phase  = ph;
      e.sector = (rot * n) / 4096;
      e.mag    = m;
      c        = ((2 * e.sector + 1) * 4096) / (2 * n);
      e.err    = rot - c;
      if (e.err > 127)  e.err = 127;
      if (e.err < -128) e.err = -128;
      return e;
   endfunction

   exp_t pend = '{default: 0};
   exp_t outx = '{default: 0};

   // Two-cycle reference delay line; held data survives bubbles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend = '{default: 0};
         outx = '{default: 0};
      end else begin
         if (pend.v) outx = pend;
         else        outx.v = 1'b0;
         pend = model(bus.in_valid, bus.pre_rot, bus.dir_pre, bus.dir, bus.mag,
                      int'(bus.mode), int'(bus.r1_th), int'(bus.r2_th));
      end
   end

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_out_valid", int'(bus.out_valid), int'(outx.v));
         check("mdl_phase",     int'(bus.phase),     outx.phase);
         check("mdl_ring",      int'(bus.ring),      outx.ring);
         check("mdl_sector",    int'(bus.sector),    outx.sector);
         check("mdl_mag_o",     int'(bus.mag_o),     outx.mag);
`ifdef PHASE_ERR_EN
         check("mdl_phase_err", int'(bus.phase_err), outx.err);
`endif
      end
   end

   task automatic drive(bit v, bit pr, bit dp, logic [6:0] d, logic [17:0] m,
                        logic [1:0] md, logic [17:0] t1, logic [17:0] t2);
      @(negedge clk);
      bus.in_valid = v;
      bus.pre_rot  = pr;
      bus.dir_pre  = dp;
      bus.dir      = d;
      bus.mag      = m;
      bus.mode     = md;
      bus.r1_th    = t1;
      bus.r2_th    = t2;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_out(string tag, int ph, int rg, int sc);
      check({tag, "_valid"},  int'(bus.out_valid), 1);
      check({tag, "_phase"},  int'(bus.phase),     ph);
      check({tag, "_ring"},   int'(bus.ring),      rg);
      check({tag, "_sector"}, int'(bus.sector),    sc);
   endtask

   initial begin
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      bus.pre_rot  = 1'b0;
      bus.dir_pre  = 1'b0;
      bus.dir      = '0;
      bus.mag      = '0;
      bus.mode     = '0;
      bus.r1_th    = '0;
      bus.r2_th    = '0;
      #2 rst_n = 1'b0;
      chk_en   = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: everything stays zero
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rst_valid",  int'(bus.out_valid), 0);
         check("rst_phase",  int'(bus.phase),     0);
         check("rst_sector", int'(bus.sector),    0);
         check("rst_mag_o",  int'(bus.mag_o),     0);
      end

      // No pre-rotation, all positive stages: 1126, inner ring
      drive(1, 0, 0, 7'h00, 18'h00200, 2'd1, 18'h00400, 18'h00800);
      idle();
      check("t1_early_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      expect_out("t1", 1126, 0, 1);
      check("t1_mag_o", int'(bus.mag_o), 'h200);

      // 3072 - 1126 = 1946, middle ring
      drive(1, 1, 1, 7'h7F, 18'h00600, 2'd1, 18'h00400, 18'h00800);
      idle();
      @(negedge clk);
      expect_out("t2", 1946, 1, 5);

      // Same angle, large magnitude: mode 1 then mode 0 back to back
      drive(1, 1, 1, 7'h7F, 18'h00900, 2'd1, 18'h00400, 18'h00800);
      drive(1, 1, 1, 7'h7F, 18'h00900, 2'd0, 18'h00400, 18'h00800);
      idle();
      expect_out("t3a", 1946, 2, 8);
      @(negedge clk);
      expect_out("t3b", 1946, 1, 5);

      // Wrap below zero, with a bubble between two samples
      drive(1, 0, 0, 7'h7F, 18'h00200, 2'd1, 18'h00400, 18'h00800);
      drive(0, 0, 0, 7'h00, 18'h00000, 2'd1, 18'h00400, 18'h00800);
      drive(1, 0, 0, 7'h7F, 18'h00900, 2'd1, 18'h00400, 18'h00800);
      expect_out("t4a", 2970, 0, 2);
      idle();
      check("t4_bubble_valid", int'(bus.out_valid), 0);
      check("t4_bubble_hold",  int'(bus.phase),     2970);
      @(negedge clk);
      expect_out("t4b", 2970, 2, 12);

      // Negative magnitude treated as zero: 0 >= r1_th=0 -> middle ring
      drive(1, 1, 0, 7'h00, 18'h3FFFF, 2'd1, 18'h00000, 18'h00800);
      idle();
      @(negedge clk);
      expect_out("t5", 2150, 1, 6);
      check("t5_mag_o", int'(bus.mag_o), -1);

      // Inverted thresholds keep priority order -> outer ring
      drive(1, 0, 0, 7'h00, 18'h00500, 2'd1, 18'h00400, 18'h00100);
      idle();
      @(negedge clk);
      expect_out("t6", 1126, 2, 4);

      // QPSK forces ring 0 regardless of magnitude
      drive(1, 0, 0, 7'h00, 18'h00900, 2'd2, 18'h00400, 18'h00800);
      idle();
      @(negedge clk);
      expect_out("t7", 1126, 0, 1);

      // Reset pulse while two samples are in flight
      drive(1, 0, 0, 7'h00, 18'h00900, 2'd1, 18'h00400, 18'h00800);
      drive(1, 1, 0, 7'h00, 18'h00900, 2'd1, 18'h00400, 18'h00800);
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t8_rst_valid", int'(bus.out_valid), 0);
      check("t8_rst_phase", int'(bus.phase),     0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t8_after_valid", int'(bus.out_valid), 0);
      drive(1, 1, 1, 7'h7F, 18'h00600, 2'd1, 18'h00400, 18'h00800);
      idle();
      check("t8_early_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      expect_out("t8", 1946, 1, 5);

      // Random stream against the reference model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 7'($urandom),
               18'($urandom), 2'($urandom), 18'($urandom_range(0, 'h1FFFF)),
               18'($urandom_range(0, 'h1FFFF)));
      end
      idle();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
